cp0_access_queue: RTL and testbench
===================================

Name: cp0_access_queue

Overview:
- Parametrised successor to the ID-stage CP0 decoder: decodes MTC0/MFC0 into CP0 read/write requests and buffers them in an in-order queue of DEPTH entries until the commit side consumes them.
- Sits between ID and the CP0 access point in the pipeline.
- Detects read-after-write hazards against queued writes to the same CP0 register.
- Stalls ID on a hazard, or forwards the queued write data when forwarding is compiled in.

Parameters:
- DATA_WIDTH, 32: width of CP0 write data.
- DEPTH, 4: queue entries; power of two, at least 2.
- REG_ADDR_WIDTH, 5: width of rs and rd.
- SEL_WIDTH, 3: width of sel. CP0 address width AW = REG_ADDR_WIDTH + SEL_WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous queue clear (exception/eret).
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  queue accepts the instruction this cycle.
- op  in  6  instruction opcode.
- rs  in  REG_ADDR_WIDTH  rs field; CP0 sub-op.
- rd  in  REG_ADDR_WIDTH  CP0 register number.
- sel  in  SEL_WIDTH  CP0 select.
- is_cp0  in  1  instruction bits [10:3] qualify as a CP0 move.
- wdata  in  DATA_WIDTH  rt value for MTC0.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_read  out  1  head is MFC0.
- out_write  out  1  head is MTC0.
- out_addr  out  AW  head address {rd, sel}.
- out_wdata  out  DATA_WIDTH  head write data, or forwarded data.
- out_fwd  out  1  head read carries forwarded data (0 without CP0_FWD_EN).
- count  out  log2(DEPTH)+1  occupied entries.
- raw_hazard  out  1  input read matches a queued write.

Behaviour:
- Decode:
  - Write when op==6'b010000 && rs==5'b00100 && is_cp0.
  - Read when op==6'b010000 && rs==5'b00000 && is_cp0.
  - Anything else is a non-access. Non-accesses are consumed (in_ready follows the same rule) and never enqueued.
- in_ready = !full && !(raw_hazard && stall rule). Full means count==DEPTH.
- No pass-through: a pop in the same cycle does not free space for a push while full.
- Push when in_valid && in_ready && decoded access. The entry stores read, write, addr={rd,sel}, wdata (zero for reads) and fwd.
- Pop when out_valid && out_ready.
- Push and pop in the same cycle are legal at any count; count is unchanged.
- Pointers wrap modulo DEPTH.
- out_valid = (count != 0). Head fields are driven from storage.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest.
- When out_valid=0, out_read, out_write, out_addr, out_wdata and out_fwd are all 0.
- raw_hazard is combinational: in_valid && decoded read && some valid queued write has addr == {rd,sel}.
  - Writes still occupying an entry match, including the head being popped that cycle.
  - Writes never match an input write.
- flush has priority over push and pop: the next cycle has count=0 and out_valid=0, and the input is ignored that cycle.
- Reset (async, rst=0): count=0, pointers=0, all outputs 0, in_ready=0 while rst=0. in_ready becomes 1 after release.
- Reset mid-operation discards all entries.

Optional Feature:
- Macro CP0_FWD_EN.
- Without the macro:
  - A hazardous read stalls: in_ready=0 until no matching write remains queued.
  - out_fwd is tied to 0.
- With the macro:
  - A hazardous read is accepted when not full.
  - Its entry stores fwd=1 and wdata = data of the youngest matching queued write.
  - The consumer uses out_wdata instead of reading CP0.
  - raw_hazard is still reported, and in_ready ignores it.

Test Plan:
- Basic write: rst 0 then 1, push MTC0 rd=12 sel=0 wdata=0x0000FF01, out_ready=1 -> next cycle out_valid=1, out_write=1, out_addr=8'h60, out_wdata=0x0000FF01; count returns to 0 after the pop.
- Fill and drain: DEPTH=4, out_ready=0, push 5 MFC0 -> in_ready=0 on the fifth, count=4. Release out_ready -> four pops in order; out_addr matches push order.
- Simultaneous push/pop at count=2 -> count stays 2; ordering preserved across pointer wrap.
- RAW hazard, without macro: queue MTC0 addr {9,0}, then present MFC0 {9,0} -> raw_hazard=1, in_ready=0 until the write pops; then accepted with out_fwd=0.
- RAW hazard, with CP0_FWD_EN: queue MTC0 {9,0}=0x11 then MTC0 {9,0}=0x22, then MFC0 {9,0} -> accepted; read entry has out_fwd=1, out_wdata=0x22.
- Flush and reset: flush with count=3 and a concurrent push -> count=0 next cycle, out_valid=0. Async rst low mid-stream -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_access_queue.sv
// cp0_access_queue: decodes MTC0/MFC0 into CP0 requests and buffers them in-order with RAW hazard detection.
// Optional macro CP0_FWD_EN: forward the youngest queued write data to hazardous reads instead of stalling.
`default_nettype none

module cp0_access_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SEL_WIDTH      = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [5:0]                            op,
  input  logic [REG_ADDR_WIDTH-1:0]             rs,
  input  logic [REG_ADDR_WIDTH-1:0]             rd,
  input  logic [SEL_WIDTH-1:0]                  sel,
  input  logic                                  is_cp0,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_read,
  output logic                                  out_write,
  output logic [REG_ADDR_WIDTH+SEL_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]                 out_wdata,
  output logic                                  out_fwd,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  raw_hazard
);

  localparam int AW = REG_ADDR_WIDTH + SEL_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [5:0]                OP_COP0 = 6'b010000;
  localparam logic [REG_ADDR_WIDTH-1:0] RS_MFC0 = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] RS_MTC0 = REG_ADDR_WIDTH'(4);

  logic                  rd_mem_q   [DEPTH];
  logic                  wr_mem_q   [DEPTH];
  logic                  fwd_mem_q  [DEPTH];
  logic [AW-1:0]         addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                  dec_rd, dec_wr, full, match, stall, push, pop;
  logic                  push_fwd;
  logic [AW-1:0]         in_addr;
  logic [DATA_WIDTH-1:0] push_data;
  logic [PW-1:0]         idx;
`ifdef CP0_FWD_EN
  logic [DATA_WIDTH-1:0] match_data;
`endif

  assign dec_rd  = (op == OP_COP0) && (rs == RS_MFC0) && is_cp0;
  assign dec_wr  = (op == OP_COP0) && (rs == RS_MTC0) && is_cp0;
  assign in_addr = {rd, sel};
  assign full    = (count_q == CW'(DEPTH));

  // Scan oldest to youngest so the last hit is the youngest matching write.
  always_comb begin
    match = 1'b0;
    idx   = '0;
`ifdef CP0_FWD_EN
    match_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && wr_mem_q[idx] && (addr_mem_q[idx] == in_addr)) begin
        match = 1'b1;
`ifdef CP0_FWD_EN
        match_data = data_mem_q[idx];
`endif
      end
    end
  end

  assign raw_hazard = in_valid && dec_rd && match;

`ifdef CP0_FWD_EN
  assign stall     = 1'b0;
  assign push_fwd  = raw_hazard;
  assign push_data = dec_wr ? wdata : (raw_hazard ? match_data : '0);
`else
  assign stall     = raw_hazard;
  assign push_fwd  = 1'b0;
  assign push_data = dec_wr ? wdata : '0;
`endif

  assign in_ready  = rst && !full && !stall;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && (dec_rd || dec_wr) && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[tail_q]   <= dec_rd;
      wr_mem_q[tail_q]   <= dec_wr;
      fwd_mem_q[tail_q]  <= push_fwd;
      addr_mem_q[tail_q] <= in_addr;
      data_mem_q[tail_q] <= push_data;
    end
  end

  assign count     = count_q;
  assign out_read  = out_valid && rd_mem_q[head_q];
  assign out_write = out_valid && wr_mem_q[head_q];
  assign out_fwd   = out_valid && fwd_mem_q[head_q];
  assign out_addr  = out_valid ? addr_mem_q[head_q] : '0;
  assign out_wdata = out_valid ? data_mem_q[head_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_cp0_access_queue.sv
// Randomised + directed scoreboard bench for cp0_access_queue against a queue-based reference model.
`default_nettype none

module tb_cp0_access_queue;

`ifdef CP0_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, is_cp0 = 1'b0, out_ready = 1'b0;
  logic [5:0]  op = '0;
  logic [4:0]  rs = '0, rd = '0;
  logic [2:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic        in_ready, out_valid, out_read, out_write, out_fwd, raw_hazard;
  logic [7:0]  out_addr;
  logic [31:0] out_wdata;
  logic [2:0]  count;

  cp0_access_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .REG_ADDR_WIDTH(5), .SEL_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rd(rd), .sel(sel), .is_cp0(is_cp0), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_read(out_read), .out_write(out_write),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_fwd(out_fwd), .count(count),
    .raw_hazard(raw_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        fwd;
  } ent_t;

  ent_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: predicts handshake outputs from the model and queues accepted entries.
  always begin
    logic   is_rd, is_wr, hit, e_haz, e_ready, do_push;
    logic [31:0] hdata;
    ent_t   e;
    @(posedge clk);
    #4;
    is_rd = (op == 6'b010000) && (rs == 5'd0) && is_cp0;
    is_wr = (op == 6'b010000) && (rs == 5'd4) && is_cp0;
    hit   = 1'b0;
    hdata = '0;
    foreach (exp_q[i])
      if (exp_q[i].wr && exp_q[i].addr == {rd, sel}) begin
        hit   = 1'b1;
        hdata = exp_q[i].data;
      end
    e_haz   = in_valid && is_rd && hit;
    e_ready = rst && (exp_q.size() < DEPTH) && !(e_haz && !FWD);
    chk("raw_hazard", raw_hazard, e_haz);
    chk("in_ready", in_ready, e_ready);
    do_push = rst && in_valid && e_ready && (is_rd || is_wr) && !flush;
    e.rd   = is_rd;
    e.wr   = is_wr;
    e.addr = {rd, sel};
    e.fwd  = FWD && e_haz;
    e.data = is_wr ? wdata : (e.fwd ? hdata : 32'h0);
    #2;
    if (flush && rst) exp_q.delete();
    else if (do_push) exp_q.push_back(e);
  end

  // Monitor: compares the presented head against the model and retires on handshake.
  always @(negedge clk) begin
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("count", count, exp_q.size());
    if (exp_q.size() != 0) begin
      chk("out_read", out_read, exp_q[0].rd);
      chk("out_write", out_write, exp_q[0].wr);
      chk("out_addr", out_addr, exp_q[0].addr);
      chk("out_wdata", out_wdata, exp_q[0].data);
      chk("out_fwd", out_fwd, exp_q[0].fwd);
      if (out_ready && !flush && rst) void'(exp_q.pop_front());
    end else begin
      chk("idle_fields", {out_read, out_write, out_fwd, out_addr, out_wdata}, 0);
    end
  end

  task automatic drive(input logic v, input logic [5:0] o, input logic [4:0] s, input logic [4:0] r,
                       input logic [2:0] sl, input logic c, input logic [31:0] wd,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; op = o; rs = s; rd = r; sel = sl; is_cp0 = c; wdata = wd;
    out_ready = ordy; flush = fl;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [2:0] sl, input logic [31:0] wd, input logic ordy);
    drive(1'b1, 6'b010000, 5'd4, r, sl, 1'b1, wd, ordy, 1'b0);
  endtask

  task automatic mfc0(input logic [4:0] r, input logic [2:0] sl, input logic ordy);
    drive(1'b1, 6'b010000, 5'd0, r, sl, 1'b1, 32'h0, ordy, 1'b0);
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'h0, 5'h0, 5'h0, 3'h0, 1'b0, 32'h0, ordy, 1'b0);
  endtask

  initial begin
    idle(1'b0, 2);
    #2 rst = 1'b1;

    // Basic write
    mtc0(5'd12, 3'd0, 32'h0000FF01, 1'b1);
    idle(1'b1, 2);

    // Fill and drain
    for (int i = 1; i <= 5; i++) mfc0(5'(i), 3'd1, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 5);

    // Concurrent push/pop at count 2 across pointer wrap
    mtc0(5'd1, 3'd0, 32'hA1, 1'b0);
    mtc0(5'd2, 3'd0, 32'hA2, 1'b0);
    for (int i = 0; i < 6; i++) mtc0(5'(i + 3), 3'd2, 32'hB0 + i, 1'b1);
    idle(1'b1, 3);

    // RAW hazard
    mtc0(5'd9, 3'd0, 32'hAB, 1'b0);
    mfc0(5'd9, 3'd0, 1'b0);
    mfc0(5'd9, 3'd0, 1'b1);
    mfc0(5'd9, 3'd0, 1'b1);
    idle(1'b1, 3);

    // Youngest-write forwarding
    mtc0(5'd9, 3'd0, 32'h11, 1'b0);
    mtc0(5'd9, 3'd0, 32'h22, 1'b0);
    mfc0(5'd9, 3'd0, 1'b0);
    idle(1'b1, 5);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) mtc0(5'(i), 3'd3, 32'hC0 + i, 1'b0);
    drive(1'b1, 6'b010000, 5'd4, 5'd7, 3'd0, 1'b1, 32'hDD, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Randomised traffic with a small address set to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      if (k <= 3)
        mtc0(5'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      else if (k <= 7)
        mfc0(5'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (k == 8)
        drive(1'b1, 6'($urandom), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 3)), 3'd0,
              1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      else
        idle(1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 49) == 0) flush = 1'b1;
    end

    // Asynchronous reset mid-stream
    mtc0(5'd5, 3'd0, 32'h55, 1'b0);
    mtc0(5'd6, 3'd0, 32'h66, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_write", out_write, 0);
    idle(1'b0, 2);
    #2 rst = 1'b1;
    mtc0(5'd12, 3'd0, 32'h0000FF01, 1'b1);
    idle(1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
